// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO sweep controller: state encoding,
// default datapath widths and the min/max tracker seed values.
package nco_ctrl_pkg;

    localparam int INCR_W_DEF   = 32;
    localparam int SAMPLE_W_DEF = 16;

    // Tracker seeds: min starts at most-positive, max at most-negative.
    localparam logic signed [SAMPLE_W_DEF-1:0] MIN_INIT = 16'sh7FFF;
    localparam logic signed [SAMPLE_W_DEF-1:0] MAX_INIT = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        REPORT  = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl_p2p_meter.sv
// Peak-to-peak window meter: tracks signed min/max over `count` valid samples
// and flags the sample that closes the window, with the amplitude including it.
module p2p_meter
    import nco_ctrl_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [15:0]                count,
    output logic [SAMPLE_W:0]          amplitude,
    output logic                       window_done
);

    localparam logic signed [SAMPLE_W-1:0] MIN_SEED = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] MAX_SEED = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [SAMPLE_W-1:0] min_reg, max_reg;
    logic signed [SAMPLE_W-1:0] min_next, max_next;
    logic [15:0]                cnt_reg;
    logic                       take;

    // Amplitude reflects the current sample so the closing sample is counted.
    always_comb begin
        take        = enable && sample_valid;
        min_next    = min_reg;
        max_next    = max_reg;
        if (take && (sample < min_reg)) min_next = sample;
        if (take && (sample > max_reg)) max_next = sample;
        amplitude   = {max_next[SAMPLE_W-1], max_next} - {min_next[SAMPLE_W-1], min_next};
        window_done = take && (cnt_reg == (count - 16'd1));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_reg <= MIN_SEED;
            max_reg <= MAX_SEED;
            cnt_reg <= '0;
        end else if (take) begin
            min_reg <= min_next;
            max_reg <= max_next;
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO sweep sequencer: owns angle_incr, steps it through a sweep and reports
// per-step peak-to-peak amplitude. SWEEP_PEAK_TRACK_EN adds peak_idx/peak_ampl.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int INCR_W         = INCR_W_DEF,
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int SETTLE_SAMPLES = 256,
    parameter int MEAS_SAMPLES   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_incr_set,
    input  logic [INCR_W-1:0]          host_incr,
    input  logic                       start,
    input  logic                       abort,
    input  logic [INCR_W-1:0]          incr_start,
    input  logic [INCR_W-1:0]          incr_step,
    input  logic [15:0]                num_steps,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [INCR_W-1:0]          angle_incr,
    output logic                       busy,
    output logic                       result_valid,
    output logic [15:0]                result_idx,
    output logic [SAMPLE_W:0]          result_ampl,
`ifdef SWEEP_PEAK_TRACK_EN
    output logic [15:0]                peak_idx,
    output logic [SAMPLE_W:0]          peak_ampl,
`endif
    output logic                       done
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
    localparam logic [15:0] MEAS_LEN    = 16'(MEAS_SAMPLES);

    state_t              state_reg, state_next;
    logic [INCR_W-1:0]   cur_incr_reg, incr_step_reg, angle_incr_reg;
    logic [15:0]         num_steps_reg, step_reg, settle_cnt_reg;
    logic                busy_reg, result_valid_reg, done_reg;
    logic [15:0]         result_idx_reg;
    logic [SAMPLE_W:0]   result_ampl_reg;
    logic [SAMPLE_W:0]   meter_ampl;
    logic                window_done;
    logic                last_step;

    p2p_meter #(.SAMPLE_W(SAMPLE_W)) u_meter (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_reg != MEASURE),
        .enable       (state_reg == MEASURE),
        .sample_valid (sample_valid),
        .sample       (sample),
        .count        (MEAS_LEN),
        .amplitude    (meter_ampl),
        .window_done  (window_done)
    );

    always_comb begin
        state_next = state_reg;
        last_step  = ({1'b0, step_reg} + 17'd1) == {1'b0, num_steps_reg};
        unique case (state_reg)
            IDLE:    if (start) state_next = (num_steps == 16'd0) ? DONE : LOAD;
            LOAD:    state_next = abort ? DONE : SETTLE;
            SETTLE:  if (abort) state_next = DONE;
                     else if (sample_valid && (settle_cnt_reg == SETTLE_LAST)) state_next = MEASURE;
            MEASURE: if (abort) state_next = DONE;
                     else if (window_done) state_next = REPORT;
            REPORT:  state_next = (abort || last_step) ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cur_incr_reg     <= '0;
            incr_step_reg    <= '0;
            num_steps_reg    <= '0;
            step_reg         <= '0;
            settle_cnt_reg   <= '0;
            angle_incr_reg   <= '0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            result_idx_reg   <= '0;
            result_ampl_reg  <= '0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            result_valid_reg <= (state_reg == MEASURE) && (state_next == REPORT);
            done_reg         <= (state_reg == DONE);
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        cur_incr_reg  <= incr_start;
                        incr_step_reg <= incr_step;
                        num_steps_reg <= num_steps;
                        step_reg      <= '0;
                        busy_reg      <= (num_steps != 16'd0);
                    end else if (host_incr_set) begin
                        angle_incr_reg <= host_incr;
                    end
                end
                LOAD: begin
                    if (!abort) angle_incr_reg <= cur_incr_reg;
                    settle_cnt_reg <= '0;
                end
                SETTLE: if (sample_valid) settle_cnt_reg <= settle_cnt_reg + 16'd1;
                MEASURE: begin
                    if (state_next == REPORT) begin
                        result_ampl_reg <= meter_ampl;
                        result_idx_reg  <= step_reg;
                    end
                end
                REPORT: begin
                    if (state_next == LOAD) begin
                        cur_incr_reg <= cur_incr_reg + incr_step_reg;
                        step_reg     <= step_reg + 16'd1;
                    end
                end
                DONE:    busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SWEEP_PEAK_TRACK_EN
    logic [15:0]       peak_idx_reg;
    logic [SAMPLE_W:0] peak_ampl_reg;

    // Strict compare keeps the earliest step when maxima tie.
    always_ff @(posedge clk) begin
        if (rst || (state_reg == IDLE && start)) begin
            peak_idx_reg  <= '0;
            peak_ampl_reg <= '0;
        end else if (state_reg == REPORT && result_ampl_reg > peak_ampl_reg) begin
            peak_idx_reg  <= result_idx_reg;
            peak_ampl_reg <= result_ampl_reg;
        end
    end

    assign peak_idx  = peak_idx_reg;
    assign peak_ampl = peak_ampl_reg;
`endif

    assign angle_incr   = angle_incr_reg;
    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign result_idx   = result_idx_reg;
    assign result_ampl  = result_ampl_reg;
    assign done         = done_reg;

endmodule
